// File: rtl/elastic_pipe_stage.sv
// Elastic valid/ready pipeline register: DEPTH-entry circular buffer with
// synchronous flush and a saturating back-pressure cycle counter.
module elastic_pipe_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [CW-1:0]    FULL_COUNT = CW'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_MAX  = '1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CNT_W-1:0] r_stall;

    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    // Ready is a pure function of occupancy, so there is no comb path from out_ready.
    assign w_in_ready  = (r_count < FULL_COUNT);
    assign w_out_valid = (r_count != '0);
    assign w_push      = in_valid & w_in_ready;
    assign w_pop       = w_out_valid & out_ready;

    assign in_ready     = w_in_ready;
    assign out_valid    = w_out_valid;
    assign out_data     = w_out_valid ? r_mem[r_rd_ptr] : '0;
    assign count        = r_count;
    assign stall_cycles = r_stall;

    always_ff @(posedge clk) begin
        if (reset && !flush && w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Flush leaves the performance counter alone; only reset clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall <= '0;
        end else if (!flush && w_out_valid && !out_ready && (r_stall != STALL_MAX)) begin
            r_stall <= r_stall + CNT_W'(1);
        end
    end

endmodule
